pipeline_stall_ctrl: RTL and testbench

//  Central stall/bubble controller for the cached pipeline. Tracks NUM_PORTS memory

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipeline_stall_ctrl_if.sv | 29 ++
 rtl/mem_port_tracker.sv | 52 +++++
 rtl/pipeline_stall_ctrl.sv | 73 +++++++
 tb/tb_pipeline_stall_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/bubble controller.
package pipe_ctrl_pkg;

   // Per-port memory request tracking state
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } port_state_t;

   // Pipeline register write-enable bit positions
   localparam int STG_PC    = 0;
   localparam int STG_IFID  = 1;
   localparam int STG_IDEX  = 2;
   localparam int STG_EXMEM = 3;
   localparam int STG_MEMWB = 4;

   // Bubble insertion mode codes
   localparam int BUBBLE_NONE = 0;
   localparam int BUBBLE_LOAD = 1;
   localparam int BUBBLE_LDST = 2;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Memory-channel / pipeline-control bundle between the pipeline and the stall controller.
interface pipeline_stall_ctrl_if #(
   parameter int NUM_PORTS  = 2,
   parameter int NUM_STAGES = 5,
   parameter int CNT_W      = 32
);
   logic [NUM_PORTS-1:0]  mem_req;
   logic [NUM_PORTS-1:0]  mem_complete;
   logic                  id_ex_mem_read;
   logic                  id_ex_mem_write;
   logic [NUM_STAGES-1:0] stage_write;
   logic                  insert_bubble;
   logic [NUM_PORTS-1:0]  port_busy;
   logic [NUM_PORTS-1:0]  timeout;
   logic [CNT_W-1:0]      stall_cycles;
   logic [CNT_W-1:0]      bubble_cycles;

   // Pipeline / memory side drives requests and observes the controls
   modport master (
      output mem_req, mem_complete, id_ex_mem_read, id_ex_mem_write,
      input  stage_write, insert_bubble, port_busy, timeout, stall_cycles, bubble_cycles
   );

   // Controller side
   modport slave (
      input  mem_req, mem_complete, id_ex_mem_read, id_ex_mem_write,
      output stage_write, insert_bubble, port_busy, timeout, stall_cycles, bubble_cycles
   );
endinterface

// File: rtl/mem_port_tracker.sv
// One memory channel: request FSM, stall (busy) generation and sticky watchdog.
module mem_port_tracker
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic req_i,
   input  logic complete_i,
   output logic busy_o,
   output logic timeout_o
);
   localparam int            WD_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES);

   port_state_t     state_q;
   logic [WD_W-1:0] wd_q;
   logic            timeout_q;
   logic            waiting;

   // Still waiting on this edge: in WAIT and no completion this cycle
   assign waiting = (state_q == WAIT) && !complete_i;

   // Busy releases in the same cycle as the completion pulse; forced low during reset
   assign busy_o    = reset_n & (((state_q == IDLE) & req_i & ~complete_i) | waiting);
   assign timeout_o = timeout_q;

   // Request FSM plus watchdog; DONE ignores req since the requester is still high
   // for the cycle in which the pipe advances
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE:    if (req_i) state_q <= complete_i ? DONE : WAIT;
            WAIT:    if (complete_i) state_q <= DONE;
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (waiting) begin
            if (wd_q != WD_LIM) wd_q <= wd_q + 1'b1;
            if (wd_q == WD_LIM - 1'b1) timeout_q <= 1'b1;
         end else begin
            wd_q <= '0;
         end
      end
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/bubble controller: freezes the pipe while any memory port is busy,
// otherwise optionally bubbles behind an ID/EX memory op; keeps perf counters.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NUM_PORTS      = 2,
   parameter int NUM_STAGES     = 5,
   parameter int BUBBLE_MODE    = 2,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   pipeline_stall_ctrl_if.slave bus
);
   localparam logic EN_LD = (BUBBLE_MODE >= BUBBLE_LOAD);
   localparam logic EN_ST = (BUBBLE_MODE == BUBBLE_LDST);

   logic [NUM_PORTS-1:0]  busy;
   logic [NUM_PORTS-1:0]  tmo;
   logic                  mem_stall;
   logic                  bubble_req;
   logic [NUM_STAGES-1:0] stage_write_d;
   logic                  insert_bubble_d;
   logic [CNT_W-1:0]      stall_cnt_q;
   logic [CNT_W-1:0]      bubble_cnt_q;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      mem_port_tracker #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_trk (
         .clk       (clk),
         .reset_n   (reset_n),
         .req_i     (bus.mem_req[p]),
         .complete_i(bus.mem_complete[p]),
         .busy_o    (busy[p]),
         .timeout_o (tmo[p])
      );
   end

   assign mem_stall  = |busy;
   assign bubble_req = reset_n & ((EN_LD & bus.id_ex_mem_read) | (EN_ST & bus.id_ex_mem_write));

   // Priority: memory stall freezes everything (and suppresses bubble), then bubble
   // holds PC and IF/ID while ID/EX takes a NOP, else everything advances
   always_comb begin
      stage_write_d   = '1;
      insert_bubble_d = 1'b0;
      if (mem_stall) begin
         stage_write_d = '0;
      end else if (bubble_req) begin
         stage_write_d[STG_IFID:STG_PC] = '0;
         insert_bubble_d                = 1'b1;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (mem_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (insert_bubble_d && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
   end

   assign bus.stage_write   = stage_write_d;
   assign bus.insert_bubble = insert_bubble_d;
   assign bus.port_busy     = busy;
   assign bus.timeout       = tmo;
   assign bus.stall_cycles  = stall_cnt_q;
   assign bus.bubble_cycles = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench: stimulus pushes hand-computed expectations into a scoreboard queue,
// a negedge monitor pops and compares. DUT A: load/store bubble, 8-cycle watchdog.
// DUT B shares A's inputs but bubbles on loads only.
module tb_pipeline_stall_ctrl;
   localparam logic [4:0] F = 5'b11111;
   localparam logic [4:0] Z = 5'b00000;
   localparam logic [4:0] B = 5'b11100;

   typedef struct {
      logic [4:0]  sw;
      logic        bub;
      logic [1:0]  busy;
      logic [1:0]  to;
      logic [31:0] sc;
      logic [31:0] bc;
      logic [4:0]  sw_b;
      logic        bub_b;
   } exp_t;

   logic clk;
   logic reset_n;
   exp_t sbq[$];
   int   n_chk;
   int   n_fail;

   pipeline_stall_ctrl_if #(.NUM_PORTS(2), .NUM_STAGES(5), .CNT_W(32)) ifa ();
   pipeline_stall_ctrl_if #(.NUM_PORTS(2), .NUM_STAGES(5), .CNT_W(32)) ifb ();

   assign ifb.mem_req         = ifa.mem_req;
   assign ifb.mem_complete    = ifa.mem_complete;
   assign ifb.id_ex_mem_read  = ifa.id_ex_mem_read;
   assign ifb.id_ex_mem_write = ifa.id_ex_mem_write;

   pipeline_stall_ctrl #(.NUM_PORTS(2), .NUM_STAGES(5), .BUBBLE_MODE(2),
                         .TIMEOUT_CYCLES(8), .CNT_W(32)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(ifa));

   pipeline_stall_ctrl #(.NUM_PORTS(2), .NUM_STAGES(5), .BUBBLE_MODE(1),
                         .TIMEOUT_CYCLES(255), .CNT_W(32)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: outputs are present every cycle; compare mid-cycle
   always @(negedge clk) begin
      if (sbq.size() != 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("stage_write",   32'(ifa.stage_write),   32'(e.sw));
         chk("insert_bubble", 32'(ifa.insert_bubble), 32'(e.bub));
         chk("port_busy",     32'(ifa.port_busy),     32'(e.busy));
         chk("timeout",       32'(ifa.timeout),       32'(e.to));
         chk("stall_cycles",  ifa.stall_cycles,       e.sc);
         chk("bubble_cycles", ifa.bubble_cycles,      e.bc);
         chk("b_stage_write", 32'(ifb.stage_write),   32'(e.sw_b));
         chk("b_insert_bubble", 32'(ifb.insert_bubble), 32'(e.bub_b));
      end
   end

   // Drive one cycle of inputs and queue what DUT A must show in that cycle.
   // DUT B differs only in not bubbling on a store.
   task automatic step(input logic [1:0] req, input logic [1:0] cmp, input logic rd,
                       input logic wr, input logic [4:0] sw, input logic bub,
                       input logic [1:0] busy, input logic [1:0] to, input int sc,
                       input int bc);
      exp_t e;
      ifa.mem_req         = req;
      ifa.mem_complete    = cmp;
      ifa.id_ex_mem_read  = rd;
      ifa.id_ex_mem_write = wr;
      e.sw = sw; e.bub = bub; e.busy = busy; e.to = to;
      e.sc = 32'(sc); e.bc = 32'(bc);
      if (busy != 2'b00) begin e.sw_b = Z; e.bub_b = 1'b0; end
      else if (rd && reset_n) begin e.sw_b = B; e.bub_b = 1'b1; end
      else begin e.sw_b = F; e.bub_b = 1'b0; end
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      reset_n = 1'b0;
      ifa.mem_req = 2'b11; ifa.mem_complete = 2'b00;
      ifa.id_ex_mem_read = 1'b0; ifa.id_ex_mem_write = 1'b0;
      @(posedge clk);
      #1;
      // 1: reset held with requests high
      step(2'b11, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 0, 0);
      step(2'b00, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 0, 0);
      reset_n = 1'b1;
      // 2: port0 miss, 4 stall cycles, DONE ignores held req
      step(2'b00, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 0, 0);
      step(2'b01, 2'b00, 0, 0, Z, 0, 2'b01, 2'b00, 0, 0);
      step(2'b01, 2'b00, 0, 0, Z, 0, 2'b01, 2'b00, 1, 0);
      step(2'b01, 2'b00, 0, 0, Z, 0, 2'b01, 2'b00, 2, 0);
      step(2'b01, 2'b00, 0, 0, Z, 0, 2'b01, 2'b00, 3, 0);
      step(2'b01, 2'b01, 0, 0, F, 0, 2'b00, 2'b00, 4, 0);
      step(2'b01, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 4, 0);
      step(2'b00, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 4, 0);
      // 3: both ports miss, port1 completes last; 7 more stall cycles
      step(2'b11, 2'b00, 0, 0, Z, 0, 2'b11, 2'b00, 4, 0);
      step(2'b11, 2'b00, 0, 0, Z, 0, 2'b11, 2'b00, 5, 0);
      step(2'b11, 2'b01, 0, 0, Z, 0, 2'b10, 2'b00, 6, 0);
      step(2'b11, 2'b00, 0, 0, Z, 0, 2'b10, 2'b00, 7, 0);
      step(2'b10, 2'b00, 0, 0, Z, 0, 2'b10, 2'b00, 8, 0);
      step(2'b10, 2'b00, 0, 0, Z, 0, 2'b10, 2'b00, 9, 0);
      step(2'b10, 2'b00, 0, 0, Z, 0, 2'b10, 2'b00, 10, 0);
      step(2'b10, 2'b10, 0, 0, F, 0, 2'b00, 2'b00, 11, 0);
      step(2'b10, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 11, 0);
      step(2'b00, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 11, 0);
      // 4: load bubbles in both modes, store bubbles only in DUT A
      step(2'b00, 2'b00, 1, 0, B, 1, 2'b00, 2'b00, 11, 0);
      step(2'b00, 2'b00, 0, 1, B, 1, 2'b00, 2'b00, 11, 1);
      step(2'b00, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 11, 2);
      // 5: stall overrides bubble; zero-latency hit does not stall
      step(2'b10, 2'b00, 1, 0, Z, 0, 2'b10, 2'b00, 11, 2);
      step(2'b10, 2'b10, 1, 0, B, 1, 2'b00, 2'b00, 12, 2);
      step(2'b10, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 12, 3);
      step(2'b01, 2'b01, 0, 0, F, 0, 2'b00, 2'b00, 12, 3);
      step(2'b01, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 12, 3);
      // bubble then stall: frozen bubble, no second bubble after release
      step(2'b00, 2'b00, 1, 0, B, 1, 2'b00, 2'b00, 12, 3);
      step(2'b01, 2'b00, 1, 0, Z, 0, 2'b01, 2'b00, 12, 4);
      step(2'b01, 2'b01, 0, 0, F, 0, 2'b00, 2'b00, 13, 4);
      step(2'b00, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 13, 4);
      // 6: port0 never completes; watchdog fires after 8th WAIT edge
      for (int k = 1; k <= 12; k++)
         step(2'b01, 2'b00, 0, 0, Z, 0, 2'b01, (k >= 10) ? 2'b01 : 2'b00, 12 + k, 4);
      reset_n = 1'b0;
      step(2'b01, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 0, 0);
      reset_n = 1'b1;
      step(2'b01, 2'b00, 0, 0, Z, 0, 2'b01, 2'b00, 0, 0);
      step(2'b00, 2'b01, 0, 0, F, 0, 2'b00, 2'b00, 1, 0);
      step(2'b00, 2'b00, 0, 0, F, 0, 2'b00, 2'b00, 1, 0);
      @(negedge clk);
      #1;
      n_chk++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
